// File: rtl/router_pkg.sv
// Shared router definitions: FSM state encoding and the default port/address
// geometry used by the controller, register block and output FIFOs.
package router_pkg;

    localparam int ROUTER_NUM_PORTS = 3;
    localparam int ROUTER_ADDR_W    = 2;

    // All eight 3-bit encodings are named, so no encoding is left undecoded.
    typedef enum logic [2:0] {
        ST_DECODE          = 3'd0,
        ST_LFD             = 3'd1,
        ST_LOAD_DATA       = 3'd2,
        ST_LOAD_PARITY     = 3'd3,
        ST_FIFO_FULL       = 3'd4,
        ST_LOAD_AFTER_FULL = 3'd5,
        ST_WAIT_EMPTY      = 3'd6,
        ST_CHECK_PARITY    = 3'd7
    } state_t;

endpackage

// File: rtl/router_port_dec.sv
// Address-to-one-hot port decoder with enable; drives the per-FIFO write strobes.
module router_port_dec #(
    parameter int ADDR_W    = 2,
    parameter int NUM_PORTS = 3
) (
    input  logic                 i_en,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic [NUM_PORTS-1:0] o_onehot
);

    // One compare per port keeps the result at most one-hot by construction.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign o_onehot[g] = i_en && (i_addr == ADDR_W'(g));
    end

endmodule

// File: rtl/router_pkt_fsm.sv
// Packet-sequencing controller for the 1xN router input path. Decodes the
// header address, walks the input register through header/payload/parity
// loading, stalls while the selected FIFO is full, and drives the per-port
// write enables and the busy back-pressure to the source.
module router_pkt_fsm
    import router_pkg::*;
#(
    parameter int NUM_PORTS = ROUTER_NUM_PORTS,
    parameter int ADDR_W    = ROUTER_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    din_addr,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_addr,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 full_state,
    output logic                 laf_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic                 busy
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_port_sel;

    logic                w_addr_valid;
    logic                w_empty_din;
    logic                w_empty_port;
    logic                w_full_sel;
    logic                w_soft_sel;
    logic                w_empty_sel;
    logic                w_hdr_ok;

    // Per-port selects done as compare loops so an out-of-range header
    // address never indexes past the port vectors; it simply matches nothing.
    always_comb begin
        w_addr_valid = 1'b0;
        w_empty_din  = 1'b0;
        w_empty_port = 1'b0;
        w_full_sel   = 1'b0;
        w_soft_sel   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (din_addr == ADDR_W'(i)) begin
                w_addr_valid = 1'b1;
                w_empty_din  = fifo_empty[i];
            end
            if (r_port_sel == ADDR_W'(i)) begin
                w_empty_port = fifo_empty[i];
                w_full_sel   = fifo_full[i];
                w_soft_sel   = soft_reset[i];
            end
        end
    end

    assign w_hdr_ok    = pkt_valid && w_addr_valid;
    assign w_empty_sel = (r_state == ST_DECODE) ? w_empty_din : w_empty_port;

    // State register, port_sel capture and next-state selection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_DECODE;
            r_port_sel <= '0;
        end else begin
            if (r_state == ST_DECODE && w_hdr_ok)
                r_port_sel <= din_addr;

            // An output-side flush of the active port aborts the packet from
            // any state; in DECODE there is no active packet to abort.
            if (r_state != ST_DECODE && w_soft_sel) begin
                r_state <= ST_DECODE;
            end else begin
                case (r_state)
                    ST_DECODE: begin
                        if (w_hdr_ok)
                            r_state <= w_empty_sel ? ST_LFD : ST_WAIT_EMPTY;
                    end
                    ST_LFD:
                        r_state <= ST_LOAD_DATA;
                    ST_LOAD_DATA: begin
                        // Full wins over end-of-packet; the parity byte is
                        // picked up again via LOAD_AFTER_FULL.
                        if (w_full_sel)
                            r_state <= ST_FIFO_FULL;
                        else if (!pkt_valid)
                            r_state <= ST_LOAD_PARITY;
                    end
                    ST_FIFO_FULL: begin
                        if (!w_full_sel)
                            r_state <= ST_LOAD_AFTER_FULL;
                    end
                    ST_LOAD_AFTER_FULL: begin
                        if (parity_done)
                            r_state <= ST_DECODE;
                        else if (low_pkt_valid)
                            r_state <= ST_LOAD_PARITY;
                        else
                            r_state <= ST_LOAD_DATA;
                    end
                    ST_LOAD_PARITY:
                        r_state <= ST_CHECK_PARITY;
                    ST_CHECK_PARITY:
                        r_state <= w_full_sel ? ST_FIFO_FULL : ST_DECODE;
                    ST_WAIT_EMPTY: begin
                        if (w_empty_sel)
                            r_state <= ST_LFD;
                    end
                    default:
                        r_state <= ST_DECODE;
                endcase
            end
        end
    end

    // Moore output decode straight off the state register.
    assign detect_addr   = (r_state == ST_DECODE);
    assign lfd_state     = (r_state == ST_LFD);
    assign ld_state      = (r_state == ST_LOAD_DATA);
    assign full_state    = (r_state == ST_FIFO_FULL);
    assign laf_state     = (r_state == ST_LOAD_AFTER_FULL);
    assign rst_int_reg   = (r_state == ST_CHECK_PARITY);
    assign write_enb_reg = (r_state == ST_LOAD_DATA)   || (r_state == ST_LOAD_PARITY) ||
                           (r_state == ST_LOAD_AFTER_FULL) || (r_state == ST_LFD);
    assign busy          = !((r_state == ST_DECODE) || (r_state == ST_LOAD_DATA));

    router_port_dec #(
        .ADDR_W    (ADDR_W),
        .NUM_PORTS (NUM_PORTS)
    ) u_port_dec (
        .i_en     (write_enb_reg),
        .i_addr   (r_port_sel),
        .o_onehot (write_enb)
    );

endmodule

// File: tb/tb_router_pkt_fsm.sv
// Bench for router_pkt_fsm: table of per-cycle stimulus with the hand-derived
// state and port_sel expected after each edge, expanded into an output bundle
// and checked through a scoreboard queue; plus directed corner sequences.
module tb_router_pkt_fsm;
    import router_pkg::*;

    logic       clk;
    logic       rst;
    logic       pkt_valid;
    logic [1:0] din_addr;
    logic [2:0] fifo_full, fifo_empty, soft_reset;
    logic       parity_done, low_pkt_valid;
    logic       detect_addr, lfd_state, ld_state, full_state, laf_state;
    logic       rst_int_reg, write_enb_reg, busy;
    logic [2:0] write_enb;

    router_pkt_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_valid     (pkt_valid),
        .din_addr      (din_addr),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .soft_reset    (soft_reset),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_addr   (detect_addr),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .full_state    (full_state),
        .laf_state     (laf_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb_reg (write_enb_reg),
        .write_enb     (write_enb),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       pv;
        logic [1:0] a;
        logic [2:0] ff;
        logic [2:0] fe;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        state_t     st;
        logic [1:0] port;
        string      tag;
    } vec_t;

    typedef struct {
        string       tag;
        logic [10:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Expected output bundle for a given state and selected port:
    // {detect, lfd, ld, full, laf, rst_int, wer, busy, write_enb[2:0]}
    function automatic logic [10:0] exp_out(input state_t s, input logic [1:0] p);
        logic       wer;
        logic [2:0] we;
        wer = (s == ST_LOAD_DATA) || (s == ST_LOAD_PARITY) ||
              (s == ST_LOAD_AFTER_FULL) || (s == ST_LFD);
        we  = 3'b000;
        if (wer) begin
            case (p)
                2'd0:    we = 3'b001;
                2'd1:    we = 3'b010;
                2'd2:    we = 3'b100;
                default: we = 3'b000;
            endcase
        end
        return {s == ST_DECODE, s == ST_LFD, s == ST_LOAD_DATA, s == ST_FIFO_FULL,
                s == ST_LOAD_AFTER_FULL, s == ST_CHECK_PARITY, wer,
                !(s == ST_DECODE || s == ST_LOAD_DATA), we};
    endfunction

    task automatic add(input logic r, input logic pv, input logic [1:0] a,
                       input logic [2:0] ff, input logic [2:0] fe, input logic [2:0] sr,
                       input logic pd, input logic lpv, input state_t st,
                       input logic [1:0] port, input string tag);
        vec_t v;
        v.r = r; v.pv = pv; v.a = a; v.ff = ff; v.fe = fe; v.sr = sr;
        v.pd = pd; v.lpv = lpv; v.st = st; v.port = port; v.tag = tag;
        tbl.push_back(v);
    endtask

    // Drive one cycle of stimulus, queue the expectation, sample after the edge.
    task automatic apply(input vec_t v);
        sb_t         e;
        logic [10:0] got;
        @(negedge clk);
        rst = v.r; pkt_valid = v.pv; din_addr = v.a; fifo_full = v.ff;
        fifo_empty = v.fe; soft_reset = v.sr; parity_done = v.pd; low_pkt_valid = v.lpv;
        e.tag = v.tag;
        e.exp = exp_out(v.st, v.port);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = {detect_addr, lfd_state, ld_state, full_state, laf_state,
               rst_int_reg, write_enb_reg, busy, write_enb};
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %b", v.tag, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: outputs got %b required %b (st=%s)",
                         e.tag, got, e.exp, v.st.name());
            end
        end
        n_tests++;
        if ($countones(write_enb) > 1) begin
            n_fail++;
            $display("FAIL %s_onehot: write_enb got %b required at most one bit", v.tag, write_enb);
        end
    endtask

    localparam logic [2:0] E = 3'b111;
    localparam logic [2:0] Z = 3'b000;

    initial begin
        vec_t hv;
        rst = 1'b0; pkt_valid = 1'b0; din_addr = 2'd0; fifo_full = Z;
        fifo_empty = E; soft_reset = Z; parity_done = 1'b0; low_pkt_valid = 1'b0;

        // 1. reset with pkt_valid high is ignored
        add(0, 1, 2'd1, Z, E, Z, 0, 0, ST_DECODE, 2'd0, "rst0");
        add(0, 1, 2'd1, Z, E, Z, 0, 0, ST_DECODE, 2'd0, "rst1");
        // 2. port 1, four payload bytes
        add(1, 1, 2'd1, Z, E, Z, 0, 0, ST_LFD,          2'd1, "p1_lfd");
        add(1, 1, 2'd0, Z, E, Z, 0, 0, ST_LOAD_DATA,    2'd1, "p1_ld1");
        add(1, 1, 2'd0, Z, E, Z, 0, 0, ST_LOAD_DATA,    2'd1, "p1_ld2");
        add(1, 1, 2'd0, Z, E, Z, 0, 0, ST_LOAD_DATA,    2'd1, "p1_ld3");
        add(1, 1, 2'd0, Z, E, Z, 0, 0, ST_LOAD_DATA,    2'd1, "p1_ld4");
        add(1, 0, 2'd0, Z, E, Z, 0, 0, ST_LOAD_PARITY,  2'd1, "p1_lp");
        add(1, 0, 2'd0, Z, E, Z, 0, 0, ST_CHECK_PARITY, 2'd1, "p1_cp");
        add(1, 0, 2'd0, Z, E, Z, 0, 0, ST_DECODE,       2'd1, "p1_dec");
        // 3. invalid address dropped, port_sel kept
        add(1, 1, 2'd3, Z, E, Z, 0, 0, ST_DECODE, 2'd1, "bad_addr0");
        add(1, 1, 2'd3, Z, E, Z, 0, 0, ST_DECODE, 2'd1, "bad_addr1");
        // 4. port 2 not empty at header
        add(1, 1, 2'd2, Z, 3'b011, Z, 0, 0, ST_WAIT_EMPTY,   2'd2, "p2_wait0");
        add(1, 1, 2'd0, Z, 3'b011, Z, 0, 0, ST_WAIT_EMPTY,   2'd2, "p2_wait1");
        add(1, 1, 2'd0, Z, E,      Z, 0, 0, ST_LFD,          2'd2, "p2_lfd");
        add(1, 1, 2'd0, Z, E,      Z, 0, 0, ST_LOAD_DATA,    2'd2, "p2_ld");
        add(1, 0, 2'd0, Z, E,      Z, 0, 0, ST_LOAD_PARITY,  2'd2, "p2_lp");
        add(1, 0, 2'd0, Z, E,      Z, 0, 0, ST_CHECK_PARITY, 2'd2, "p2_cp");
        add(1, 0, 2'd0, Z, E,      Z, 0, 0, ST_DECODE,       2'd2, "p2_dec");
        // 5. port 0 full mid-payload, resume via low_pkt_valid
        add(1, 1, 2'd0, Z,      E, Z, 0, 0, ST_LFD,             2'd0, "p0_lfd");
        add(1, 1, 2'd0, Z,      E, Z, 0, 0, ST_LOAD_DATA,       2'd0, "p0_ld");
        add(1, 1, 2'd0, 3'b001, E, Z, 0, 0, ST_FIFO_FULL,       2'd0, "p0_full0");
        add(1, 0, 2'd0, 3'b001, E, Z, 0, 0, ST_FIFO_FULL,       2'd0, "p0_full1");
        add(1, 0, 2'd0, Z,      E, Z, 0, 1, ST_LOAD_AFTER_FULL, 2'd0, "p0_laf");
        add(1, 0, 2'd0, Z,      E, Z, 0, 1, ST_LOAD_PARITY,     2'd0, "p0_lp");
        add(1, 0, 2'd0, Z,      E, Z, 0, 0, ST_CHECK_PARITY,    2'd0, "p0_cp");
        add(1, 0, 2'd0, Z,      E, Z, 0, 0, ST_DECODE,          2'd0, "p0_dec");
        // 5b. full and end-of-packet together, LAF back to LD, CP into full, LAF done
        add(1, 1, 2'd0, Z,      E, Z, 0, 0, ST_LFD,             2'd0, "q_lfd");
        add(1, 1, 2'd0, Z,      E, Z, 0, 0, ST_LOAD_DATA,       2'd0, "q_ld");
        add(1, 0, 2'd0, 3'b001, E, Z, 0, 0, ST_FIFO_FULL,       2'd0, "q_full_wins");
        add(1, 0, 2'd0, 3'b110, E, Z, 0, 0, ST_LOAD_AFTER_FULL, 2'd0, "q_laf_other_full");
        add(1, 0, 2'd0, Z,      E, Z, 0, 0, ST_LOAD_DATA,       2'd0, "q_laf_to_ld");
        add(1, 0, 2'd0, Z,      E, Z, 0, 0, ST_LOAD_PARITY,     2'd0, "q_lp");
        add(1, 0, 2'd0, 3'b001, E, Z, 0, 0, ST_CHECK_PARITY,    2'd0, "q_cp");
        add(1, 0, 2'd0, 3'b001, E, Z, 0, 0, ST_FIFO_FULL,       2'd0, "q_cp_full");
        add(1, 0, 2'd0, Z,      E, Z, 0, 0, ST_LOAD_AFTER_FULL, 2'd0, "q_laf2");
        add(1, 0, 2'd0, Z,      E, Z, 1, 0, ST_DECODE,          2'd0, "q_pdone");
        // 6. soft reset on active port only; ignored in DECODE
        add(1, 0, 2'd1, Z, E, 3'b010, 0, 0, ST_DECODE,    2'd0, "sr_in_decode");
        add(1, 1, 2'd1, Z, E, Z,      0, 0, ST_LFD,       2'd1, "s_lfd");
        add(1, 1, 2'd0, Z, E, Z,      0, 0, ST_LOAD_DATA, 2'd1, "s_ld");
        add(1, 1, 2'd0, Z, E, 3'b001, 0, 0, ST_LOAD_DATA, 2'd1, "s_other_ign");
        add(1, 1, 2'd0, Z, E, 3'b010, 0, 0, ST_DECODE,    2'd1, "s_flush");

        foreach (tbl[i]) apply(tbl[i]);

        // Reset mid-packet: back to DECODE with port_sel cleared.
        hv = '{r:1, pv:1, a:2'd2, ff:Z, fe:E, sr:Z, pd:0, lpv:0, st:ST_LFD, port:2'd2, tag:"mr_lfd"};
        apply(hv);
        hv.a = 2'd0; hv.st = ST_LOAD_DATA; hv.tag = "mr_ld";
        apply(hv);
        hv.r = 1'b0; hv.st = ST_DECODE; hv.port = 2'd0; hv.tag = "mr_reset";
        apply(hv);
        hv.r = 1'b1; hv.a = 2'd3; hv.tag = "mr_bad_after";
        apply(hv);
        hv.a = 2'd0; hv.st = ST_LFD; hv.tag = "mr_p0_lfd";
        apply(hv);
        hv.st = ST_LOAD_DATA; hv.tag = "mr_p0_ld";
        apply(hv);

        // Soft reset beats a held FIFO_FULL; also aborts WAIT_EMPTY.
        hv.ff = 3'b001; hv.st = ST_FIFO_FULL; hv.tag = "sf_full";
        apply(hv);
        hv.sr = 3'b001; hv.st = ST_DECODE; hv.tag = "sf_flush_full";
        apply(hv);
        hv.ff = Z; hv.sr = Z; hv.a = 2'd1; hv.fe = 3'b101; hv.st = ST_WAIT_EMPTY;
        hv.port = 2'd1; hv.tag = "sw_wait";
        apply(hv);
        hv.sr = 3'b010; hv.st = ST_DECODE; hv.tag = "sw_flush_wait";
        apply(hv);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
